// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : boot_pkg
//  Description : Shared constants for the instruction-memory boot loader:
//                FSM state encoding, default frame start byte and frame
//                field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

   // Frame field widths
   localparam int c_BYTE_W         = 8;
   localparam int c_WORD_W         = 32;
   localparam int c_COUNT_W        = 16;
   localparam int c_BYTES_PER_WORD = 4;

   // Default frame start byte
   localparam logic [c_BYTE_W-1:0] c_MAGIC_DEFAULT = 8'hA5;

   // Loader FSM state encoding
   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_CNT_LO = 3'd1;
   localparam logic [2:0] c_ST_CNT_HI = 3'd2;
   localparam logic [2:0] c_ST_DATA   = 3'd3;
   localparam logic [2:0] c_ST_CSUM   = 3'd4;
   localparam logic [2:0] c_ST_DONE   = 3'd5;
   localparam logic [2:0] c_ST_ERR    = 3'd6;

endpackage : boot_pkg
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : loader_timeout
//  Description : Inter-byte watchdog. Counts idle cycles while enabled and
//                flags expiry in the cycle the count would reach
//                TIMEOUT_CYC-1. A clear in the same cycle suppresses expiry,
//                so a byte arriving on the last allowed cycle is accepted.
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset
//                clr     - restart the count (byte received)
//                en      - count enable (frame in progress)
//                expire  - timeout reached this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_timeout #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int c_CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYC - 2);

   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr || !en) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // r_cnt holds (idle cycles so far - 1); expiry fires on the idle cycle
   // that completes TIMEOUT_CYC-1 without a byte.
   assign expire = en && !clr && (r_cnt == c_LIMIT);

endmodule : loader_timeout
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Byte-stream boot loader. Parses frames of the form
//                MAGIC, CNT_LO, CNT_HI, 4*N data bytes, CSUM, assembles
//                little-endian 32-bit words and writes them into imem.
//                Holds the CPU in reset until a checksum-valid image loads.
//  Ports       : clk          - system clock
//                rst          - synchronous active-high reset
//                rx_valid     - one-cycle byte strobe from UART receiver
//                rx_data      - received byte
//                imem_we      - one-cycle imem write strobe
//                imem_addr    - imem word address
//                imem_wdata   - imem write data
//                cpu_rst_hold - 1 keeps the CPU in reset
//                done         - image loaded and verified (sticky)
//                err          - frame aborted (cleared by next MAGIC)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
   import boot_pkg::*;
#(
   parameter int          ADDR_W      = 8,
   parameter logic [7:0]  MAGIC       = c_MAGIC_DEFAULT,
   parameter int          TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_hold,
   output logic              done,
   output logic              err
);

   // Capacity in words, sized to compare against a 16-bit count exactly
   localparam logic [c_COUNT_W:0] c_CAPACITY = (c_COUNT_W+1)'(2**ADDR_W);

   logic [2:0]           r_state;
   logic [7:0]           r_cnt_lo;
   logic [c_COUNT_W-1:0] r_count;
   logic [ADDR_W:0]      r_widx;
   logic [1:0]           r_byte_idx;
   logic [23:0]          r_word_lo;
   logic [7:0]           r_csum;
   logic                 r_we;
   logic [ADDR_W-1:0]    r_addr;
   logic [31:0]          r_wdata;

   logic [c_COUNT_W-1:0] w_count_rx;
   logic [ADDR_W:0]      w_widx_next;
   logic                 w_last_word;
   logic                 w_to_en;
   logic                 w_timeout;

   assign w_count_rx  = {rx_data, r_cnt_lo};
   assign w_widx_next = r_widx + 1'b1;
   assign w_last_word = ((c_COUNT_W+1)'(w_widx_next) == {1'b0, r_count});

   // Watchdog runs only while a frame is in progress
   assign w_to_en = (r_state == c_ST_CNT_LO) || (r_state == c_ST_CNT_HI) ||
                    (r_state == c_ST_DATA)   || (r_state == c_ST_CSUM);

   loader_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (rx_valid),
      .en     (w_to_en),
      .expire (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_ST_IDLE;
         r_cnt_lo   <= '0;
         r_count    <= '0;
         r_widx     <= '0;
         r_byte_idx <= '0;
         r_word_lo  <= '0;
         r_csum     <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (rx_valid && (rx_data == MAGIC)) begin
                  r_state <= c_ST_CNT_LO;
               end
            end

            c_ST_CNT_LO: begin
               if (rx_valid) begin
                  r_cnt_lo <= rx_data;
                  r_state  <= c_ST_CNT_HI;
               end else if (w_timeout) begin
                  r_state <= c_ST_ERR;
               end
            end

            c_ST_CNT_HI: begin
               if (rx_valid) begin
                  r_count    <= w_count_rx;
                  r_widx     <= '0;
                  r_byte_idx <= '0;
                  r_csum     <= '0;
                  if ({1'b0, w_count_rx} > c_CAPACITY) begin
                     r_state <= c_ST_ERR;
                  end else if (w_count_rx == '0) begin
                     r_state <= c_ST_CSUM;
                  end else begin
                     r_state <= c_ST_DATA;
                  end
               end else if (w_timeout) begin
                  r_state <= c_ST_ERR;
               end
            end

            c_ST_DATA: begin
               if (rx_valid) begin
                  r_csum     <= r_csum ^ rx_data;
                  r_byte_idx <= r_byte_idx + 1'b1;
                  case (r_byte_idx)
                     2'd0: r_word_lo[7:0]   <= rx_data;
                     2'd1: r_word_lo[15:8]  <= rx_data;
                     2'd2: r_word_lo[23:16] <= rx_data;
                     default: begin
                        // Fourth byte completes the word: write next cycle
                        r_we    <= 1'b1;
                        r_addr  <= r_widx[ADDR_W-1:0];
                        r_wdata <= {rx_data, r_word_lo};
                        r_widx  <= w_widx_next;
                        if (w_last_word) begin
                           r_state <= c_ST_CSUM;
                        end
                     end
                  endcase
               end else if (w_timeout) begin
                  r_state <= c_ST_ERR;
               end
            end

            c_ST_CSUM: begin
               if (rx_valid) begin
                  r_state <= (rx_data == r_csum) ? c_ST_DONE : c_ST_ERR;
               end else if (w_timeout) begin
                  r_state <= c_ST_ERR;
               end
            end

            c_ST_DONE: begin
               // Image locked until rst
               r_state <= c_ST_DONE;
            end

            c_ST_ERR: begin
               if (rx_valid && (rx_data == MAGIC)) begin
                  r_state <= c_ST_CNT_LO;
               end
            end

            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign imem_we      = r_we;
   assign imem_addr    = r_addr;
   assign imem_wdata   = r_wdata;
   assign done         = (r_state == c_ST_DONE);
   assign err          = (r_state == c_ST_ERR);
   assign cpu_rst_hold = (r_state != c_ST_DONE);

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader (ADDR_W=2,
//                TIMEOUT_CYC=16). Expected imem writes are queued as frames
//                are driven and compared when imem_we pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        imem_we;
   logic [1:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst_hold;
   logic        done;
   logic        err;

   int          n_checks;
   int          n_errors;
   int          n_writes;
   int          w_start;
   logic        prev_we;
   wr_t         exp_q[$];
   logic [31:0] img [0:3];

   imem_loader #(
      .ADDR_W      (2),
      .MAGIC       (8'hA5),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_rst_hold (cpu_rst_hold),
      .done         (done),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Write monitor / scoreboard consumer
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         n_writes++;
         check("we_spacing", 32'(prev_we), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_we", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(imem_addr), 32'(e.addr));
            check("wr_data", imem_wdata, e.data);
         end
      end
      prev_we = imem_we;
   end

   // Called at a negedge; drives one byte then one idle cycle
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      exp_q.delete();
   endtask

   // Data words from img[] followed by CSUM (xored with corrupt)
   task automatic send_payload(input int n, input logic [7:0] corrupt, input bit expect_wr);
      logic [7:0] cs;
      logic [31:0] w;
      wr_t e;
      cs = 8'h00;
      for (int i = 0; i < n; i++) begin
         w = img[i];
         for (int b = 0; b < 4; b++) begin
            if (b == 3 && expect_wr) begin
               e.addr = 2'(i);
               e.data = w;
               exp_q.push_back(e);
            end
            cs = cs ^ w[8*b +: 8];
            send_byte(w[8*b +: 8]);
         end
      end
      send_byte(cs ^ corrupt);
   endtask

   task automatic send_frame(input int n, input logic [7:0] corrupt, input bit expect_wr);
      send_byte(8'hA5);
      send_byte(8'(n));
      send_byte(8'(n >> 8));
      send_payload(n, corrupt, expect_wr);
   endtask

   task automatic check_status(input string tag, input logic d, input logic e);
      check({tag, "_done"}, 32'(done), 32'(d));
      check({tag, "_err"},  32'(err),  32'(e));
      check({tag, "_hold"}, 32'(cpu_rst_hold), 32'(!d));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      n_writes = 0;
      prev_we  = 1'b0;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      do_reset();

      // Reset values
      check("rst_we",    32'(imem_we), 32'd0);
      check("rst_addr",  32'(imem_addr), 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check_status("rst", 1'b0, 1'b0);

      // Nominal 2-word load: A5 02 00 13 00 00 00 93 00 A0 00 20
      img[0] = 32'h0000_0013;
      img[1] = 32'h00A0_0093;
      w_start = n_writes;
      send_frame(2, 8'h00, 1'b1);
      check_status("nominal", 1'b1, 1'b0);
      check("nominal_writes", 32'(n_writes - w_start), 32'd2);

      // Bad checksum (21), then correct resend from ERR
      do_reset();
      w_start = n_writes;
      send_frame(2, 8'h01, 1'b1);
      check_status("badcsum", 1'b0, 1'b1);
      check("badcsum_writes", 32'(n_writes - w_start), 32'd2);
      send_frame(2, 8'h00, 1'b1);
      check_status("resend", 1'b1, 1'b0);

      // Zero count
      do_reset();
      w_start = n_writes;
      send_frame(0, 8'h00, 1'b1);
      check_status("zero", 1'b1, 1'b0);
      check("zero_writes", 32'(n_writes - w_start), 32'd0);

      // Overflow: N=5 > 4
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h05);
      send_byte(8'h00);
      check_status("ovf", 1'b0, 1'b1);

      // Full capacity N=4
      do_reset();
      for (int i = 0; i < 4; i++) img[i] = $urandom;
      w_start = n_writes;
      send_frame(4, 8'h00, 1'b1);
      check_status("full", 1'b1, 1'b0);
      check("full_writes", 32'(n_writes - w_start), 32'd4);

      // Garbage before MAGIC, then lock after DONE
      do_reset();
      img[0] = 32'hDEAD_BEEF;
      img[1] = 32'h1234_5678;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h13);
      send_frame(2, 8'h00, 1'b1);
      check_status("garbage", 1'b1, 1'b0);
      w_start = n_writes;
      send_frame(1, 8'h00, 1'b0);
      check_status("locked", 1'b1, 1'b0);
      check("locked_writes", 32'(n_writes - w_start), 32'd0);

      // Timeout: stop after A5 02
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h02);
      idle(13);
      check("to_before", 32'(err), 32'd0);
      idle(1);
      check("to_expired", 32'(err), 32'd1);

      // Byte arriving exactly on idle cycle 15 is accepted
      do_reset();
      img[0] = 32'hCAFE_0001;
      img[1] = 32'h0BAD_F00D;
      send_byte(8'hA5);
      send_byte(8'h02);
      idle(13);
      send_byte(8'h00);
      check("to_edge_err", 32'(err), 32'd0);
      send_payload(2, 8'h00, 1'b1);
      check_status("to_edge", 1'b1, 1'b0);

      // rst mid-DATA after byte 2 of word 0
      do_reset();
      img[0] = 32'h0000_0013;
      img[1] = 32'h00A0_0093;
      w_start = n_writes;
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h13);
      send_byte(8'h00);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_we",    32'(imem_we), 32'd0);
      check("midrst_addr",  32'(imem_addr), 32'd0);
      check("midrst_wdata", imem_wdata, 32'd0);
      check_status("midrst", 1'b0, 1'b0);
      rst = 1'b0;
      idle(6);
      check("midrst_writes", 32'(n_writes - w_start), 32'd0);
      send_frame(2, 8'h00, 1'b1);
      check_status("after_rst", 1'b1, 1'b0);
      check("after_rst_writes", 32'(n_writes - w_start), 32'd2);

      idle(4);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_imem_loader
`default_nettype wire
